// File: rtl/pl_stage_4_pkg.sv
// Shared constants, FSM encoding and modular add for the u = r0 + ep (mod Q) stage.
// Pure definitions: no latency, no flow control.
package pl_stage_4_pkg;

  localparam int N  = 512;
  localparam int Q  = 12289;
  localparam int AW = 9;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Single conditional subtract: both operands are already reduced below Q.
  function automatic logic [13:0] mod_add(input logic [13:0] a, input logic [13:0] b);
    logic [14:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 15'(Q)) s = s - 15'(Q);
    return s[13:0];
  endfunction

endpackage

// File: rtl/pl_stage_4_pingpong_ram.sv
// Two N x DW banks: writes land in bank_sel_i, reads come from the other bank, 1-cycle read.
// Read data holds while re_i is low, so a stalled consumer sees stable data.
module pl_stage_4_pingpong_ram
  import pl_stage_4_pkg::*;
(
  input  logic          clk,
  input  logic          bank_sel_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] bank0_q [N];
  logic [DW-1:0] bank1_q [N];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && !bank_sel_i) bank0_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (we_i && bank_sel_i) bank1_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= bank_sel_i ? bank0_q[raddr_i] : bank1_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pl_stage_4.sv
// Sweeps the read bank once per start_stage, writing u=(r0+ep) mod Q and passing r1 through.
// Issue-to-write latency 2 cycles, start-to-done N+3; en=0 freezes everything and blanks writes.
module pl_stage_4
  import pl_stage_4_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start_stage,
  output logic          done_stage,
  input  logic          we_r0,
  input  logic [AW-1:0] addr_r0,
  input  logic [DW-1:0] din_r0,
  input  logic          we_ep,
  input  logic [AW-1:0] addr_ep,
  input  logic [DW-1:0] din_ep,
  input  logic          we_r1,
  input  logic [AW-1:0] addr_r1,
  input  logic [DW-1:0] din_r1,
  output logic          we_u,
  output logic [AW-1:0] addr_u,
  output logic [DW-1:0] dout_u,
  output logic          we_bs,
  output logic [AW-1:0] addr_bs,
  output logic [DW-1:0] dout_bs
);

  state_t        state_q, state_d;
  logic [AW-1:0] ctr_q, ctr_d;
  logic          drain_q, drain_d;
  logic          wr_bank_q, wr_bank_d;
  logic          start_ok, issue;

  logic          v1_q;
  logic [AW-1:0] a1_q;
  logic          out_vld_q;
  logic [AW-1:0] out_addr_q;
  logic [DW-1:0] out_u_q, out_bs_q;

  logic [DW-1:0] r0_rd, ep_rd, r1_rd;
  logic [3:0]    unused_hi;

  pl_stage_4_pingpong_ram u_ram_r0 (
    .clk(clk), .bank_sel_i(wr_bank_q),
    .we_i(we_r0), .waddr_i(addr_r0), .wdata_i(din_r0),
    .re_i(en), .raddr_i(ctr_q), .rdata_o(r0_rd)
  );

  pl_stage_4_pingpong_ram u_ram_ep (
    .clk(clk), .bank_sel_i(wr_bank_q),
    .we_i(we_ep), .waddr_i(addr_ep), .wdata_i(din_ep),
    .re_i(en), .raddr_i(ctr_q), .rdata_o(ep_rd)
  );

  pl_stage_4_pingpong_ram u_ram_r1 (
    .clk(clk), .bank_sel_i(wr_bank_q),
    .we_i(we_r1), .waddr_i(addr_r1), .wdata_i(din_r1),
    .re_i(en), .raddr_i(ctr_q), .rdata_o(r1_rd)
  );

  // Operands are < Q, so only the low 14 bits feed the adder.
  assign unused_hi = {r0_rd[DW-1:14], ep_rd[DW-1:14]};

  assign start_ok  = (state_q == S_IDLE) && start_stage && en;
  assign wr_bank_d = wr_bank_q ^ start_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ctr_q     <= '0;
      drain_q   <= 1'b0;
      wr_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      drain_q   <= drain_d;
      wr_bank_q <= wr_bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    drain_d = drain_q;
    if (en) begin
      drain_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_stage) begin
            state_d = S_RUN;
            ctr_d   = '0;
          end
        end
        S_RUN: begin
          ctr_d = ctr_q + 1'b1;
          if (ctr_q == AW'(N - 1)) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          drain_d = ~drain_q;
          if (drain_q) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    issue      = 1'b0;
    done_stage = 1'b0;
    case (state_q)
      S_RUN:   issue      = 1'b1;
      S_DONE:  done_stage = en;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      a1_q       <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_u_q    <= '0;
      out_bs_q   <= '0;
    end else if (en) begin
      v1_q       <= issue;
      a1_q       <= ctr_q;
      out_vld_q  <= v1_q;
      out_addr_q <= v1_q ? a1_q : '0;
      out_u_q    <= v1_q ? {2'b00, mod_add(r0_rd[13:0], ep_rd[13:0])} : '0;
      out_bs_q   <= v1_q ? r1_rd : '0;
    end
  end

  // A held result is released only in a cycle where en is high, so it is written exactly once.
  assign we_u    = out_vld_q & en;
  assign we_bs   = out_vld_q & en;
  assign addr_u  = we_u  ? out_addr_q : '0;
  assign addr_bs = we_bs ? out_addr_q : '0;
  assign dout_u  = we_u  ? out_u_q    : '0;
  assign dout_bs = we_bs ? out_bs_q   : '0;

endmodule

// File: tb/tb_pl_stage_4.sv
// Directed bench for pl_stage_4: sums, wrap, passthrough, ping-pong, stall and reset abort.
module tb_pl_stage_4;
  import pl_stage_4_pkg::*;

  logic          clk, rst, en, start_stage, done_stage;
  logic          we_r0, we_ep, we_r1, we_u, we_bs;
  logic [AW-1:0] addr_r0, addr_ep, addr_r1, addr_u, addr_bs;
  logic [DW-1:0] din_r0, din_ep, din_r1, dout_u, dout_bs;

  pl_stage_4 dut (
    .clk(clk), .rst(rst), .en(en), .start_stage(start_stage), .done_stage(done_stage),
    .we_r0(we_r0), .addr_r0(addr_r0), .din_r0(din_r0),
    .we_ep(we_ep), .addr_ep(addr_ep), .din_ep(din_ep),
    .we_r1(we_r1), .addr_r1(addr_r1), .din_r1(din_r1),
    .we_u(we_u), .addr_u(addr_u), .dout_u(dout_u),
    .we_bs(we_bs), .addr_bs(addr_bs), .dout_bs(dout_bs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   r0;
    logic [15:0]   ep;
    logic [15:0]   r1;
    logic [15:0]   exp_u;
  } vec_t;

  vec_t        vt [10];
  int          checks = 0, failures = 0;
  int          cyc = 0, nw = 0, ndone = 0, done_cyc = 0, exp_addr = 0;
  logic [15:0] src_r0 [N], src_ep [N], src_r1 [N];
  logic [15:0] exp_u [N], exp_bs [N], cap_u [N], cap_bs [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic monitor();
    if (rst) begin
      exp_addr = 0;
    end else begin
      if (we_u || we_bs) begin
        chk("we_u", 64'(we_u), 64'd1);
        chk("we_bs", 64'(we_bs), 64'd1);
        chk("en_on_write", 64'(en), 64'd1);
        chk("addr_u", 64'(addr_u), 64'(exp_addr));
        chk("addr_bs", 64'(addr_bs), 64'(exp_addr));
        cap_u[exp_addr]  = dout_u;
        cap_bs[exp_addr] = dout_bs;
        exp_addr = (exp_addr + 1) % N;
        nw++;
      end else begin
        chk("idle_zero", 64'({addr_u, addr_bs, dout_u, dout_bs}), 64'd0);
      end
      if (done_stage) begin
        ndone++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive_wr(input bit we, input int a);
    we_r0 = we; we_ep = we; we_r1 = we;
    addr_r0 = we ? AW'(a) : '0; addr_ep = addr_r0; addr_r1 = addr_r0;
    din_r0 = we ? src_r0[a] : '0;
    din_ep = we ? src_ep[a] : '0;
    din_r1 = we ? src_r1[a] : '0;
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) begin
      drive_wr(1'b1, i);
      step();
    end
    drive_wr(1'b0, 0);
  endtask

  task automatic run_sweep(input string nm, input int stall_len, input bit write_y, input bit ign_start);
    int nw0, nd0, start_cyc;
    bit seen;
    nw0 = nw; nd0 = ndone; seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      cap_u[i] = 16'hDEAD; cap_bs[i] = 16'hDEAD;
    end
    start_stage = 1'b1;
    start_cyc = cyc;
    step();
    start_stage = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (ign_start) start_stage = (k == 50);
      if (stall_len > 0 && k == 100) en = 1'b0;
      if (stall_len > 0 && k == 100 + stall_len) en = 1'b1;
      drive_wr(write_y && k < N, (k < N) ? k : 0);
      step();
      if (ndone != nd0) begin
        seen = 1'b1;
        break;
      end
    end
    drive_wr(1'b0, 0);
    start_stage = 1'b0;
    en = 1'b1;
    chk({nm, " done_seen"}, 64'(seen), 64'd1);
    chk({nm, " done_latency"}, 64'(done_cyc - start_cyc), 64'(N + 3 + stall_len));
    repeat (3) step();
    chk({nm, " done_pulses"}, 64'(ndone - nd0), 64'd1);
    chk({nm, " write_count"}, 64'(nw - nw0), 64'(N));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s dout_u[%0d]", nm, i), 64'(cap_u[i]), 64'(exp_u[i]));
      chk($sformatf("%s dout_bs[%0d]", nm, i), 64'(cap_bs[i]), 64'(exp_bs[i]));
    end
  endtask

  initial begin
    int nw0, nd0;
    vt[0] = '{9'd0,   16'd12288, 16'd12288, 16'hFFFF, 16'd12287};
    vt[1] = '{9'd1,   16'd12288, 16'd1,     16'h0000, 16'd0};
    vt[2] = '{9'd2,   16'd0,     16'd0,     16'h1234, 16'd0};
    vt[3] = '{9'd100, 16'd6000,  16'd6289,  16'hA0A0, 16'd0};
    vt[4] = '{9'd101, 16'd6000,  16'd6288,  16'h5A5A, 16'd12288};
    vt[5] = '{9'd200, 16'd12000, 16'd500,   16'h8001, 16'd211};
    vt[6] = '{9'd300, 16'd100,   16'd12188, 16'h7FFE, 16'd12288};
    vt[7] = '{9'd400, 16'd1,     16'd2,     16'h00FF, 16'd3};
    vt[8] = '{9'd510, 16'd12288, 16'd0,     16'hFF00, 16'd12288};
    vt[9] = '{9'd511, 16'd4096,  16'd8193,  16'hC3C3, 16'd0};

    rst = 1'b1; en = 1'b1; start_stage = 1'b0;
    drive_wr(1'b0, 0);
    repeat (3) step();
    chk("reset we", 64'({we_u, we_bs, done_stage}), 64'd0);
    chk("reset addr", 64'({addr_u, addr_bs}), 64'd0);
    chk("reset dout", 64'({dout_u, dout_bs}), 64'd0);
    rst = 1'b0;
    step();

    // Basic sum 3i plus r1 passthrough.
    for (int i = 0; i < N; i++) begin
      src_r0[i] = 16'(i); src_ep[i] = 16'(2 * i); src_r1[i] = 16'hA000 | 16'(i);
      exp_u[i] = 16'(3 * i); exp_bs[i] = 16'hA000 | 16'(i);
    end
    load();
    run_sweep("basic", 0, 1'b0, 1'b0);

    // Table vectors overlaid on a 2i background.
    for (int i = 0; i < N; i++) begin
      src_r0[i] = 16'(i); src_ep[i] = 16'(i); src_r1[i] = 16'(i);
      exp_u[i] = 16'(2 * i); exp_bs[i] = 16'(i);
    end
    for (int t = 0; t < 10; t++) begin
      src_r0[vt[t].addr] = vt[t].r0; src_ep[vt[t].addr] = vt[t].ep; src_r1[vt[t].addr] = vt[t].r1;
      exp_u[vt[t].addr] = vt[t].exp_u; exp_bs[vt[t].addr] = vt[t].r1;
    end
    load();
    run_sweep("table", 0, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("vec%0d u", t), 64'(cap_u[vt[t].addr]), 64'(vt[t].exp_u));
      chk($sformatf("vec%0d bs", t), 64'(cap_bs[vt[t].addr]), 64'(vt[t].r1));
    end

    // Ping-pong: X swept while Y is written, stray start mid-run; then Y swept.
    for (int i = 0; i < N; i++) begin
      src_r0[i] = 16'(12288 - i); src_ep[i] = 16'(2 * i); src_r1[i] = 16'h5000 + 16'(i);
      exp_u[i] = (i == 0) ? 16'd12288 : 16'(i - 1); exp_bs[i] = 16'h5000 + 16'(i);
    end
    load();
    for (int i = 0; i < N; i++) begin
      src_r0[i] = 16'(5 * i); src_ep[i] = 16'd7; src_r1[i] = 16'hFFFF - 16'(i);
    end
    run_sweep("pp_x", 0, 1'b1, 1'b1);
    for (int i = 0; i < N; i++) begin
      exp_u[i] = 16'(5 * i + 7); exp_bs[i] = 16'hFFFF - 16'(i);
    end
    run_sweep("pp_y", 0, 1'b0, 1'b0);

    // Stall of 5 cycles at ctr=100.
    for (int i = 0; i < N; i++) begin
      src_r0[i] = 16'(i); src_ep[i] = 16'(3 * i); src_r1[i] = 16'h3C00 | 16'(i);
      exp_u[i] = 16'(4 * i); exp_bs[i] = 16'h3C00 | 16'(i);
    end
    load();
    run_sweep("stall", 5, 1'b0, 1'b0);

    // Reset at ctr=300 aborts; a fresh start afterwards re-reads the stall batch.
    for (int i = 0; i < N; i++) begin
      src_r0[i] = 16'd1; src_ep[i] = 16'd1; src_r1[i] = 16'd0;
    end
    load();
    nw0 = nw; nd0 = ndone;
    start_stage = 1'b1;
    step();
    start_stage = 1'b0;
    repeat (300) step();
    chk("rst pre_writes", 64'(nw - nw0), 64'd298);
    rst = 1'b1;
    step();
    chk("rst outputs", 64'({we_u, we_bs, done_stage, addr_u, addr_bs, dout_u, dout_bs}), 64'd0);
    rst = 1'b0;
    repeat (600) step();
    chk("rst no_done", 64'(ndone - nd0), 64'd0);
    chk("rst no_writes", 64'(nw - nw0), 64'd298);
    run_sweep("post_rst", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
